// File: rtl/mem_lsu_pkg.sv
// Shared op codes, exception codes and FSM encoding for the MEM-stage load/store unit.
// LSU_UNALIGNED_EN decides whether LWL/LWR/SWL/SWR count as defined ops.
package mem_lsu_pkg;

  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LBU = 4'h1;
  localparam logic [3:0] OP_LH  = 4'h2;
  localparam logic [3:0] OP_LHU = 4'h3;
  localparam logic [3:0] OP_LW  = 4'h4;
  localparam logic [3:0] OP_LWL = 4'h5;
  localparam logic [3:0] OP_LWR = 4'h6;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_SWL = 4'hB;
  localparam logic [3:0] OP_SWR = 4'hC;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;
  localparam logic [1:0] EXC_DBE  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  function automatic logic op_defined(input logic [3:0] op);
    logic def;
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
      OP_SB, OP_SH, OP_SW:                 def = 1'b1;
`ifdef LSU_UNALIGNED_EN
      OP_LWL, OP_LWR, OP_SWL, OP_SWR:      def = 1'b1;
`endif
      default:                             def = 1'b0;
    endcase
    return def;
  endfunction

  // Partial-word ops (LWL/LWR/SWL/SWR) never fault on alignment.
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] k);
    logic mis;
    case (op)
      OP_LH, OP_LHU, OP_SH: mis = k[0];
      OP_LW, OP_SW:         mis = (k != 2'b00);
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Request, response and data-RAM signals of the load/store unit.
// slave = LSU side, master = pipeline/RAM environment side.
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [3:0]        req_op_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;
  logic [4:0]        req_rd_i;

  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [31:0]       resp_rdata_o;
  logic [4:0]        resp_rd_o;
  logic              resp_we_o;
  logic              resp_exc_o;
  logic [1:0]        resp_exc_code_o;
  logic [ADDR_W-1:0] resp_badvaddr_o;

  logic              ram_ce_o;
  logic              ram_we_o;
  logic [31:0]       ram_addr_o;
  logic [3:0]        ram_vldbyte_o;
  logic [31:0]       ram_data_o;
  logic [31:0]       ram_data_i;

  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_rd_i,
    output req_ready_o,
    output resp_valid_o, resp_rdata_o, resp_rd_o, resp_we_o,
           resp_exc_o, resp_exc_code_o, resp_badvaddr_o,
    input  resp_ready_i,
    output ram_ce_o, ram_we_o, ram_addr_o, ram_vldbyte_o, ram_data_o,
    input  ram_data_i
  );

  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_rd_i,
    input  req_ready_o,
    input  resp_valid_o, resp_rdata_o, resp_rd_o, resp_we_o,
           resp_exc_o, resp_exc_code_o, resp_badvaddr_o,
    output resp_ready_i,
    input  ram_ce_o, ram_we_o, ram_addr_o, ram_vldbyte_o, ram_data_o,
    output ram_data_i
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational big-endian lane steering: store lane enables/data and load extract/merge.
// Partial-word ops are only decoded when LSU_UNALIGNED_EN is defined.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  k_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] ram_rdata_i,
  output logic [3:0]  vldbyte_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  // sh_hi = 8*(3-k): shift that brings lane 3-k down to bits [7:0]
  logic [4:0]  sh_hi;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign sh_hi    = {~k_i, 3'b000};
  assign byte_sel = 8'(ram_rdata_i >> sh_hi);
  assign half_sel = k_i[1] ? ram_rdata_i[15:0] : ram_rdata_i[31:16];

`ifdef LSU_UNALIGNED_EN
  logic [4:0] sh_lo;
  assign sh_lo = {k_i, 3'b000};
`endif

  always_comb begin
    vldbyte_o = 4'b0000;
    wdata_o   = '0;
    rdata_o   = '0;
    case (op_i)
      OP_SB: begin
        vldbyte_o = 4'b1000 >> k_i;
        wdata_o   = {4{rt_i[7:0]}};
      end
      OP_SH: begin
        vldbyte_o = k_i[1] ? 4'b0011 : 4'b1100;
        wdata_o   = {2{rt_i[15:0]}};
      end
      OP_SW: begin
        vldbyte_o = 4'b1111;
        wdata_o   = rt_i;
      end
      OP_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: rdata_o = {24'h000000, byte_sel};
      OP_LH:  rdata_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU: rdata_o = {16'h0000, half_sel};
      OP_LW:  rdata_o = ram_rdata_i;
`ifdef LSU_UNALIGNED_EN
      OP_LWL: rdata_o = (ram_rdata_i << sh_lo) | (rt_i & ~(32'hFFFF_FFFF << sh_lo));
      OP_LWR: rdata_o = (ram_rdata_i >> sh_hi) | (rt_i & ~(32'hFFFF_FFFF >> sh_hi));
      OP_SWL: begin
        vldbyte_o = 4'b1111 >> k_i;
        wdata_o   = rt_i >> sh_lo;
      end
      OP_SWR: begin
        vldbyte_o = 4'b1111 << ~k_i;
        wdata_o   = rt_i << sh_hi;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one request at a time, alignment/range checks, RAM cycle, registered response.
// Define LSU_UNALIGNED_EN to enable LWL/LWR/SWL/SWR.
//
// state    | meaning
// S_IDLE   | waiting for a request, ready high
// S_ACCESS | RAM cycle for the captured request; load data latched at the edge
// S_RESP   | response valid and held until resp_ready_i
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int ADDR_LIMIT = 252
) (
  input logic      clk,
  input logic      rst,
  mem_lsu_if.slave bus
);
  state_e            state_q, state_d, req_next;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;

  logic [31:0]       rdata_q;
  logic [4:0]        resp_rd_q;
  logic              we_q;
  logic              exc_q;
  logic [1:0]        code_q;
  logic [ADDR_W-1:0] badv_q;

  logic              req_ready, accept, in_access;
  logic              req_defined, req_misaligned, req_dbe, req_exc;
  logic [1:0]        req_code;
  logic [3:0]        al_vld;
  logic [31:0]       al_wdata, al_rdata;

  assign in_access      = (state_q == S_ACCESS);
  assign req_ready      = (state_q == S_IDLE) | ((state_q == S_RESP) & bus.resp_ready_i);
  assign accept         = bus.req_valid_i & req_ready;
  assign req_defined    = op_defined(bus.req_op_i);
  assign req_misaligned = op_misaligned(bus.req_op_i, bus.req_addr_i[1:0]);
  assign req_dbe        = (bus.req_addr_i >= ADDR_W'(ADDR_LIMIT));
  assign req_exc        = req_defined & (req_misaligned | req_dbe);
  // Alignment outranks the range check.
  assign req_code       = req_misaligned ? (bus.req_op_i[3] ? EXC_ADES : EXC_ADEL) : EXC_DBE;
  assign req_next       = (req_defined & ~req_exc) ? S_ACCESS : S_RESP;

  mem_lsu_align u_align (
    .op_i        (op_q),
    .k_i         (addr_q[1:0]),
    .rt_i        (wdata_q),
    .ram_rdata_i (bus.ram_data_i),
    .vldbyte_o   (al_vld),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    bus.req_ready_o   = req_ready;
    bus.resp_valid_o  = (state_q == S_RESP);
    // Reset in the ACCESS cycle must kill the RAM write.
    bus.ram_ce_o      = in_access & ~rst;
    bus.ram_we_o      = in_access & op_q[3] & ~rst;
    bus.ram_addr_o    = in_access ? 32'(addr_q) : 32'h0;
    bus.ram_vldbyte_o = in_access ? al_vld : 4'b0000;
    bus.ram_data_o    = in_access ? al_wdata : 32'h0;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = req_next;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (bus.resp_ready_i) state_d = accept ? req_next : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      rdata_q   <= '0;
      resp_rd_q <= '0;
      we_q      <= 1'b0;
      exc_q     <= 1'b0;
      code_q    <= EXC_NONE;
      badv_q    <= '0;
    end else if (accept) begin
      op_q      <= bus.req_op_i;
      addr_q    <= bus.req_addr_i;
      wdata_q   <= bus.req_wdata_i;
      rd_q      <= bus.req_rd_i;
      resp_rd_q <= bus.req_rd_i;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      exc_q     <= req_exc;
      code_q    <= req_exc ? req_code : EXC_NONE;
      badv_q    <= req_exc ? bus.req_addr_i : '0;
    end else if (in_access) begin
      rdata_q   <= op_q[3] ? 32'h0 : al_rdata;
      we_q      <= ~op_q[3];
    end
  end

  assign bus.resp_rdata_o    = rdata_q;
  assign bus.resp_rd_o       = resp_rd_q;
  assign bus.resp_we_o       = we_q;
  assign bus.resp_exc_o      = exc_q;
  assign bus.resp_exc_code_o = code_q;
  assign bus.resp_badvaddr_o = badv_q;

endmodule
